// File: rtl/mips_ex_alu_muldiv.sv
// -----------------------------------------------------------------------------
// mips_ex_alu_muldiv
//   Iterative multiply/divide unit sitting beside the EX-stage ALU. Executes
//   MULT/MULTU/DIV/DIVU at one bit per cycle and owns the architectural HI/LO
//   registers, which MTHI/MTLO write directly and MFHI/MFLO read directly.
//
//   Request handshake: a request is accepted on a rising edge where
//   muldiv_req_valid & muldiv_req_ready are both high and muldiv_flush is low.
//   muldiv_req_ready is high only in IDLE; requests presented while busy are
//   ignored, so EX must hold the request (stall) until ready is seen.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   muldiv_req_valid    request present this cycle
//   muldiv_req_ready    unit idle, request accepted when valid & ready
//   muldiv_op1/op2      rs / rt operands
//   muldiv_mult..mtlo   one-hot-ish op select, priority mult>multu>div>divu>mthi>mtlo
//   muldiv_flush        abort any in-flight op; HI/LO untouched
//   muldiv_busy         FSM not in IDLE
//   muldiv_done         one-cycle pulse after HI/LO are written by a mul/div
//   muldiv_hi/lo        HI / LO registers
// -----------------------------------------------------------------------------
module mips_ex_alu_muldiv #(
   parameter  int DATA_WIDTH = 32,
   localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  muldiv_req_valid,
   output logic                  muldiv_req_ready,
   input  logic [DATA_WIDTH-1:0] muldiv_op1,
   input  logic [DATA_WIDTH-1:0] muldiv_op2,
   input  logic                  muldiv_mult,
   input  logic                  muldiv_multu,
   input  logic                  muldiv_div,
   input  logic                  muldiv_divu,
   input  logic                  muldiv_mthi,
   input  logic                  muldiv_mtlo,
   input  logic                  muldiv_flush,
   output logic                  muldiv_busy,
   output logic                  muldiv_done,
   output logic [DATA_WIDTH-1:0] muldiv_hi,
   output logic [DATA_WIDTH-1:0] muldiv_lo
);

   localparam int W = DATA_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [2*W-1:0]       acc_q, acc_d;     // product, or {remainder, quotient}
   logic [W-1:0]         a_q, a_d;         // multiplicand magnitude / divisor magnitude
   logic [W-1:0]         b_q, b_d;         // multiplier (shifts right) / dividend (shifts left)
   logic                 is_div_q, is_div_d;
   logic                 neg_q, neg_d;     // negate product / quotient in FIX
   logic                 rem_neg_q, rem_neg_d;
   logic                 div_zero_q, div_zero_d;
   logic [W-1:0]         hi_q, hi_d;
   logic [W-1:0]         lo_q, lo_d;
   logic                 done_q, done_d;

   // ---------------- op decode (fixed priority) ----------------
   logic sel_mult, sel_multu, sel_div, sel_divu, sel_mthi, sel_mtlo;
   logic sel_signed, sel_start, sel_is_div;
   logic accept;

   assign sel_mult   = muldiv_mult;
   assign sel_multu  = ~muldiv_mult & muldiv_multu;
   assign sel_div    = ~muldiv_mult & ~muldiv_multu & muldiv_div;
   assign sel_divu   = ~muldiv_mult & ~muldiv_multu & ~muldiv_div & muldiv_divu;
   assign sel_mthi   = ~muldiv_mult & ~muldiv_multu & ~muldiv_div & ~muldiv_divu & muldiv_mthi;
   assign sel_mtlo   = ~muldiv_mult & ~muldiv_multu & ~muldiv_div & ~muldiv_divu &
                       ~muldiv_mthi & muldiv_mtlo;
   assign sel_signed = sel_mult | sel_div;
   assign sel_is_div = sel_div | sel_divu;
   assign sel_start  = sel_mult | sel_multu | sel_div | sel_divu;

   // Flush wins over a same-cycle accept.
   assign accept = muldiv_req_valid & (state_q == ST_IDLE) & ~muldiv_flush;

   // Operand magnitudes. -2^(W-1) negates to itself, which read as unsigned
   // is exactly the magnitude 2^(W-1), so W bits suffice here.
   logic          op1_neg, op2_neg;
   logic [W-1:0]  op1_mag, op2_mag;

   assign op1_neg = sel_signed & muldiv_op1[W-1];
   assign op2_neg = sel_signed & muldiv_op2[W-1];
   assign op1_mag = op1_neg ? (~muldiv_op1 + 1'b1) : muldiv_op1;
   assign op2_mag = op2_neg ? (~muldiv_op2 + 1'b1) : muldiv_op2;

   // ---------------- iteration datapath ----------------
   // Multiply: add multiplicand into the upper half when the multiplier LSB is
   // set, then shift the W+1 bit sum (with carry) and the lower half right.
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_acc_next;

   assign mul_sum      = {1'b0, acc_q[2*W-1:W]} + (b_q[0] ? {1'b0, a_q} : '0);
   assign mul_acc_next = {mul_sum, acc_q[W-1:1]};

   // Divide: shift the next dividend bit into the partial remainder (W+1 bits
   // wide so it never overflows), subtract the divisor when it fits.
   logic [W:0]     div_shift;
   logic           div_ge;
   logic [W-1:0]   div_diff;
   logic [W-1:0]   div_rem;
   logic [2*W-1:0] div_acc_next;

   assign div_shift    = {acc_q[2*W-1:W], b_q[W-1]};
   assign div_ge       = div_shift >= {1'b0, a_q};
   // When div_ge holds the true difference is below the divisor, so the low
   // W bits are exact.
   assign div_diff     = div_shift[W-1:0] - a_q;
   assign div_rem      = div_ge ? div_diff : div_shift[W-1:0];
   assign div_acc_next = {div_rem, acc_q[W-2:0], div_ge};

   // ---------------- sign fix-up ----------------
   logic [2*W-1:0] fix_prod;
   logic [W-1:0]   fix_quo;
   logic [W-1:0]   fix_rem;

   assign fix_prod = neg_q ? (~acc_q + 1'b1) : acc_q;
   // Divide by zero leaves |op1| as remainder, so HI = op1 falls out naturally;
   // only the quotient is forced to all ones.
   assign fix_quo  = div_zero_q ? '1 :
                     (neg_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0]);
   assign fix_rem  = rem_neg_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];

   // ---------------- next state ----------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      a_d        = a_q;
      b_d        = b_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      rem_neg_d  = rem_neg_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;

      if (muldiv_flush) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (sel_start) begin
                     state_d    = ST_CALC;
                     cnt_d      = '0;
                     acc_d      = '0;
                     is_div_d   = sel_is_div;
                     neg_d      = op1_neg ^ op2_neg;
                     rem_neg_d  = op1_neg;
                     div_zero_d = (muldiv_op2 == '0);
                     if (sel_is_div) begin
                        a_d = op2_mag;
                        b_d = op1_mag;
                     end else begin
                        a_d = op1_mag;
                        b_d = op2_mag;
                     end
                  end else if (sel_mthi) begin
                     hi_d = muldiv_op1;
                  end else if (sel_mtlo) begin
                     lo_d = muldiv_op1;
                  end
               end
            end
            ST_CALC: begin
               cnt_d = cnt_q + 1'b1;
               if (is_div_q) begin
                  acc_d = div_acc_next;
                  b_d   = b_q << 1;
               end else begin
                  acc_d = mul_acc_next;
                  b_d   = b_q >> 1;
               end
               if (cnt_q == CNT_WIDTH'(W - 1)) begin
                  state_d = ST_FIX;
               end
            end
            ST_FIX: begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               if (is_div_q) begin
                  hi_d = fix_rem;
                  lo_d = fix_quo;
               end else begin
                  hi_d = fix_prod[2*W-1:W];
                  lo_d = fix_prod[W-1:0];
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         a_q        <= a_d;
         b_q        <= b_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         rem_neg_q  <= rem_neg_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
      end
   end

   assign muldiv_req_ready = (state_q == ST_IDLE);
   assign muldiv_busy      = (state_q != ST_IDLE);
   assign muldiv_done      = done_q;
   assign muldiv_hi        = hi_q;
   assign muldiv_lo        = lo_q;

endmodule

// File: tb/tb_mips_ex_alu_muldiv.sv
// -----------------------------------------------------------------------------
// tb_mips_ex_alu_muldiv
//   Directed bench for the multiply/divide unit at DATA_WIDTH=32 and 8.
//   Drivers push the hand-computed {HI,LO} into an expected queue per
//   instance; monitors pop and compare whenever muldiv_done is seen.
// -----------------------------------------------------------------------------
module tb_mips_ex_alu_muldiv;

   localparam logic [5:0] OP_MULT  = 6'b100000;
   localparam logic [5:0] OP_MULTU = 6'b010000;
   localparam logic [5:0] OP_DIV   = 6'b001000;
   localparam logic [5:0] OP_DIVU  = 6'b000100;
   localparam logic [5:0] OP_MTHI  = 6'b000010;
   localparam logic [5:0] OP_MTLO  = 6'b000001;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- 32-bit instance ----------------
   logic        valid32 = 1'b0, flush32 = 1'b0;
   logic [5:0]  ops32 = '0;
   logic [31:0] op1_32 = '0, op2_32 = '0;
   logic        ready32, busy32, done32;
   logic [31:0] hi32, lo32;

   mips_ex_alu_muldiv #(.DATA_WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst),
      .muldiv_req_valid(valid32), .muldiv_req_ready(ready32),
      .muldiv_op1(op1_32), .muldiv_op2(op2_32),
      .muldiv_mult(ops32[5]), .muldiv_multu(ops32[4]),
      .muldiv_div(ops32[3]), .muldiv_divu(ops32[2]),
      .muldiv_mthi(ops32[1]), .muldiv_mtlo(ops32[0]),
      .muldiv_flush(flush32), .muldiv_busy(busy32), .muldiv_done(done32),
      .muldiv_hi(hi32), .muldiv_lo(lo32)
   );

   // ---------------- 8-bit instance ----------------
   logic       valid8 = 1'b0, flush8 = 1'b0;
   logic [5:0] ops8 = '0;
   logic [7:0] op1_8 = '0, op2_8 = '0;
   logic       ready8, busy8, done8;
   logic [7:0] hi8, lo8;

   mips_ex_alu_muldiv #(.DATA_WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .muldiv_req_valid(valid8), .muldiv_req_ready(ready8),
      .muldiv_op1(op1_8), .muldiv_op2(op2_8),
      .muldiv_mult(ops8[5]), .muldiv_multu(ops8[4]),
      .muldiv_div(ops8[3]), .muldiv_divu(ops8[2]),
      .muldiv_mthi(ops8[1]), .muldiv_mtlo(ops8[0]),
      .muldiv_flush(flush8), .muldiv_busy(busy8), .muldiv_done(done8),
      .muldiv_hi(hi8), .muldiv_lo(lo8)
   );

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];
   logic [15:0] exp8_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && done32) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done32_unexpected: got done with hi=%h lo=%h, expected no done", hi32, lo32);
         end else begin
            check("result32", {hi32, lo32}, exp_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && done8) begin
         if (exp8_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done8_unexpected: got done with hi=%h lo=%h, expected no done", hi8, lo8);
         end else begin
            check("result8", {48'd0, hi8, lo8}, {48'd0, exp8_q.pop_front()});
         end
      end
   end

   // ---------------- drivers ----------------
   // Cycle 1 is the cycle right after the accept edge; done is due in cycle W+2
   // and ready must stay low in every cycle before it.
   task automatic do_op32(input string name, input logic [5:0] ops, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input bit b2b);
      int lat, rdy_hi;
      exp_q.push_back({eh, el});
      if (!b2b) @(negedge clk);
      check({name, "_ready_before"}, {63'd0, ready32}, 64'd1);
      valid32 = 1'b1; ops32 = ops; op1_32 = a; op2_32 = b;
      @(posedge clk); #1;
      valid32 = 1'b0; ops32 = '0;
      lat = 0; rdy_hi = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (done32) begin
            lat = k;
            break;
         end
         if (ready32) rdy_hi++;
      end
      check({name, "_latency"}, 64'(lat), 64'd34);
      check({name, "_ready_low"}, 64'(rdy_hi), 64'd0);
   endtask

   task automatic do_op8(input string name, input logic [5:0] ops, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] eh, input logic [7:0] el);
      int lat;
      exp8_q.push_back({eh, el});
      @(negedge clk);
      valid8 = 1'b1; ops8 = ops; op1_8 = a; op2_8 = b;
      @(posedge clk); #1;
      valid8 = 1'b0; ops8 = '0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done8) begin
            lat = k;
            break;
         end
      end
      check({name, "_latency"}, 64'(lat), 64'd10);
   endtask

   // Single-cycle request on the 32-bit unit with no mul/div response expected.
   task automatic pulse32(input logic [5:0] ops, input logic [31:0] a, input logic flush);
      @(negedge clk);
      valid32 = 1'b1; ops32 = ops; op1_32 = a; op2_32 = 32'd5; flush32 = flush;
      @(posedge clk); #1;
      valid32 = 1'b0; ops32 = '0; flush32 = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (2) @(negedge clk);
      check("reset_hilo32", {hi32, lo32}, 64'd0);
      check("reset_flags32", {61'd0, ready32, busy32, done32}, 64'b100);
      check("reset_hilo8", {48'd0, hi8, lo8}, 64'd0);
      rst = 1'b0;

      do_op32("mult_7_m3",     OP_MULT,  32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      do_op32("multu_max",     OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
      do_op32("div_m7_2",      OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      do_op32("divu_9_0",      OP_DIVU,  32'h9,        32'h0,        32'h00000009, 32'hFFFFFFFF, 1'b0);
      do_op32("div_ovf",       OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1);
      do_op32("div_m9_0",      OP_DIV,   32'hFFFFFFF7, 32'h0,        32'hFFFFFFF7, 32'hFFFFFFFF, 1'b0);
      do_op32("divu_100_7",    OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
      do_op32("div_7_m2",      OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);
      do_op32("mult_minsq",    OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
      do_op32("prio_mult",     OP_MULT | OP_DIVU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);

      // MTHI/MTLO: update next edge, unit stays idle
      pulse32(OP_MTHI, 32'h1234, 1'b0);
      check("mthi", {hi32, lo32}, {32'h1234, 32'hFFFFFFFE});
      check("mthi_idle", {62'd0, ready32, busy32}, 64'b10);
      pulse32(OP_MTHI | OP_MTLO, 32'h5555, 1'b0);
      check("prio_mthi", {hi32, lo32}, {32'h5555, 32'hFFFFFFFE});
      pulse32(OP_MTLO, 32'hABCD, 1'b0);
      check("mtlo", {hi32, lo32}, {32'h5555, 32'hABCD});
      pulse32(6'b000000, 32'h7777, 1'b0);
      check("no_op", {hi32, lo32}, {32'h5555, 32'hABCD});
      check("no_op_idle", {62'd0, ready32, busy32}, 64'b10);

      // Flush beats a same-cycle accept
      pulse32(OP_MULT, 32'd5, 1'b1);
      check("flush_drops_accept", {63'd0, busy32}, 64'd0);

      // Flush mid-op at cycle 10
      pulse32(OP_MULT, 32'd5, 1'b0);
      check("mult_started", {63'd0, busy32}, 64'd1);
      for (int k = 1; k < 10; k++) @(negedge clk);
      flush32 = 1'b1;
      @(posedge clk); #1;
      flush32 = 1'b0;
      check("flush_idle", {62'd0, ready32, busy32}, 64'b10);
      check("flush_hilo", {hi32, lo32}, {32'h5555, 32'hABCD});
      repeat (40) @(negedge clk);
      check("flush_hilo_later", {hi32, lo32}, {32'h5555, 32'hABCD});
      do_op32("mult_2_3", OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

      // Asynchronous reset in the middle of a divide
      pulse32(OP_DIVU, 32'd100, 1'b0);
      for (int k = 1; k < 20; k++) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midreset_hilo", {hi32, lo32}, 64'd0);
      check("midreset_flags", {61'd0, ready32, busy32, done32}, 64'b100);
      @(negedge clk);
      rst = 1'b0;

      // DATA_WIDTH = 8 regression
      do_op8("w8_mult_7_m3", OP_MULT,  8'h07, 8'hFD, 8'hFF, 8'hEB);
      do_op8("w8_multu_max", OP_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01);
      do_op8("w8_div_m7_2",  OP_DIV,   8'hF9, 8'h02, 8'hFF, 8'hFD);
      do_op8("w8_divu_9_0",  OP_DIVU,  8'h09, 8'h00, 8'h09, 8'hFF);
      do_op8("w8_div_ovf",   OP_DIV,   8'h80, 8'hFF, 8'h00, 8'h80);
      do_op8("w8_divu_200_7", OP_DIVU, 8'd200, 8'd7, 8'd4,  8'd28);

      repeat (5) @(negedge clk);
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      check("exp8_q_drained", 64'(exp8_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected test completion");
      $fatal(1, "watchdog");
   end

endmodule
